// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'b00,
        LSU_SIZE_HALF = 2'b01,
        LSU_SIZE_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUSY = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - load lane select with sign/zero extension
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        half    = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            LSU_SIZE_BYTE: data_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
            LSU_SIZE_HALF: data_o = {{16{half[15] & ~unsigned_i}}, half};
            default:       data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - req/ack memory-access stage; LSU_TIMEOUT_EN adds a bus timeout
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        misaligned,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    lsu_state_e  state_q;
    logic        load_valid_q, misaligned_q, mem_req_q, mem_we_q;
    logic [31:0] load_data_q, mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [1:0]  off_q, size_q;
    logic        uns_q;

    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] aligned;

    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b0000;
        wdata_d = storeData;
        case (reqSize)
            LSU_SIZE_BYTE: begin
                legal_d = 1'b1;
                be_d    = 4'b0001 << aluResult[1:0];
                wdata_d = {4{storeData[7:0]}};
            end
            LSU_SIZE_HALF: begin
                legal_d = ~aluResult[0];
                be_d    = aluResult[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{storeData[15:0]}};
            end
            LSU_SIZE_WORD: begin
                legal_d = (aluResult[1:0] == 2'b00);
                be_d    = 4'b1111;
            end
            default: legal_d = 1'b0;
        endcase
    end

    lsu_load_align u_align (
        .word_i     (memRdata),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          bus_error_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            load_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_error_q  <= 1'b0;
`endif
            case (state_q)
                LSU_IDLE: begin
                    if (reqValid && legal_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= reqWrite;
                        mem_addr_q  <= {aluResult[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        off_q       <= aluResult[1:0];
                        size_q      <= reqSize;
                        uns_q       <= reqUnsigned;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                        state_q     <= LSU_BUSY;
                    end else if (reqValid) begin
                        misaligned_q <= 1'b1;
                    end
                end
                LSU_BUSY: begin
                    // An ack on the terminal timeout cycle takes precedence.
                    if (memAck) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= LSU_IDLE;
                        end else begin
                            load_data_q  <= aligned;
                            load_valid_q <= 1'b1;
                            state_q      <= LSU_RESP;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        bus_error_q <= 1'b1;
                        state_q     <= LSU_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                LSU_RESP: state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    assign busError = bus_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign busError       = 1'b0;
`endif

    assign stall      = (state_q == LSU_BUSY) ||
                        (state_q == LSU_IDLE && reqValid && legal_d);
    assign loadData   = load_data_q;
    assign loadValid  = load_valid_q;
    assign misaligned = misaligned_q;
    assign memReq     = mem_req_q;
    assign memWe      = mem_we_q;
    assign memAddr    = mem_addr_q;
    assign memBe      = mem_be_q;
    assign memWdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst, reqValid, reqWrite, reqUnsigned, memAck;
    logic [1:0]  reqSize;
    logic [31:0] aluResult, storeData, memRdata;
    logic        stall, loadValid, misaligned, busError, memReq, memWe;
    logic [31:0] loadData, memAddr, memWdata;
    logic [3:0]  memBe;

    int errors = 0;
    int checks = 0;

    int          stalls, busy;
    logic        lv, mis, done;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    int          bad;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .aluResult(aluResult),
        .storeData(storeData), .stall(stall), .loadData(loadData),
        .loadValid(loadValid), .misaligned(misaligned), .busError(busError),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
        .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, acks on the delay-th BUSY cycle, runs until stall drops.
    task automatic access(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input int delay);
        stalls = 0; busy = 0; lv = 0; mis = 0; done = 0;
        bus_addr = 'x; bus_wdata = 'x; bus_be = 'x; bus_we = 'x;
        cyc();
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = un;
        aluResult = addr; storeData = sd;
        #1;
        if (stall) stalls++;
        for (int i = 0; i < 40; i++) begin
            cyc();
            reqValid = 1'b0; memAck = 1'b0;
            #1;
            if (memReq) begin
                busy++;
                bus_addr = memAddr; bus_be = memBe; bus_we = memWe; bus_wdata = memWdata;
                if (busy == delay) begin
                    memAck = 1'b1; memRdata = rdata;
                end
            end
            if (!stall) begin
                lv = loadValid; mis = misaligned; done = 1'b1;
                break;
            end
            stalls++;
        end
        check("access_done", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
        aluResult = '0; storeData = '0; memRdata = '0; memAck = 1'b0;
        cyc(); cyc();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memWe", 32'(memWe), 32'd0);
        check("rst_outs", {loadValid, misaligned, busError}, 32'd0);
        check("rst_loadData", loadData, 32'h0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_memBe", 32'(memBe), 32'h0);
        check("rst_memWdata", memWdata, 32'h0);
        rst = 1'b0;

        access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
        check("wl_addr", bus_addr, 32'h0000_0010);
        check("wl_be", 32'(bus_be), 32'hF);
        check("wl_we", 32'(bus_we), 32'd0);
        check("wl_stalls", 32'(stalls), 32'd4);
        check("wl_lv", 32'(lv), 32'd1);
        check("wl_data", loadData, 32'hDEAD_BEEF);
        cyc();
        check("wl_lv_pulse", 32'(loadValid), 32'd0);

        access(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1);
        check("bls_be", 32'(bus_be), 32'h8);
        check("bls_addr", bus_addr, 32'h0000_0010);
        check("bls_stalls", 32'(stalls), 32'd2);
        check("bls_data", loadData, 32'hFFFF_FF80);
        access(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1);
        check("blu_data", loadData, 32'h0000_0080);

        access(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 2);
        check("hl_be", 32'(bus_be), 32'hC);
        check("hl_data", loadData, 32'hFFFF_8001);

        access(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h0, 1);
        check("hs_we", 32'(bus_we), 32'd1);
        check("hs_be", 32'(bus_be), 32'hC);
        check("hs_wdata", bus_wdata, 32'hABCD_ABCD);
        check("hs_addr", bus_addr, 32'h0000_0020);
        check("hs_stalls", 32'(stalls), 32'd2);
        check("hs_lv", 32'(lv), 32'd0);
        check("hs_hold_loadData", loadData, 32'hFFFF_8001);

        access(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 1);
        check("bs_be", 32'(bus_be), 32'h2);
        check("bs_wdata", bus_wdata, 32'hA5A5_A5A5);
        access(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344, 32'h0, 2);
        check("ws_be", 32'(bus_be), 32'hF);
        check("ws_wdata", bus_wdata, 32'h1122_3344);
        check("ws_stalls", 32'(stalls), 32'd3);

        access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1);
        check("mw_mis", 32'(mis), 32'd1);
        check("mw_busy", 32'(busy), 32'd0);
        check("mw_stalls", 32'(stalls), 32'd0);
        cyc();
        check("mw_pulse", 32'(misaligned), 32'd0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0, 32'h0, 1);
        check("mh_mis", 32'(mis), 32'd1);
        access(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1);
        check("s11_mis", 32'(mis), 32'd1);
        check("s11_busy", 32'(busy), 32'd0);

        cyc();
        memAck = 1'b1; memRdata = 32'h5555_5555;
        cyc();
        memAck = 1'b0;
        #1;
        check("idle_ack_memReq", 32'(memReq), 32'd0);
        check("idle_ack_outs", {stall, loadValid, busError}, 32'd0);
        check("idle_ack_loadData", loadData, 32'hFFFF_8001);

        cyc();
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; aluResult = 32'h0000_0030;
        cyc();
        reqValid = 1'b0;
        cyc();
        #1;
        check("rb_busy_memReq", 32'(memReq), 32'd1);
        rst = 1'b1;
        cyc();
        #1;
        check("rb_memReq", 32'(memReq), 32'd0);
        check("rb_outs", {stall, loadValid, busError}, 32'd0);
        rst = 1'b0;
        cyc();
        #1;
        check("rb_after_lv", 32'(loadValid), 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 2);
        check("rb_next_data", loadData, 32'hCAFE_F00D);
        check("rb_next_stalls", 32'(stalls), 32'd3);

`ifdef LSU_TIMEOUT_EN
        cyc();
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; aluResult = 32'h0000_0080;
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            reqValid = 1'b0;
            #1;
            if (!memReq || busError || !stall) bad++;
        end
        check("to_busy_cycles", 32'(bad), 32'd0);
        cyc();
        #1;
        check("to_busError", 32'(busError), 32'd1);
        check("to_memReq", 32'(memReq), 32'd0);
        check("to_stall_lv", {stall, loadValid}, 32'd0);
        cyc();
        #1;
        check("to_pulse", 32'(busError), 32'd0);
`else
        cyc();
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; aluResult = 32'h0000_0080;
        bad = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            reqValid = 1'b0;
            #1;
            if (!memReq || busError || !stall) bad++;
        end
        check("nto_wait", 32'(bad), 32'd0);
        memAck = 1'b1; memRdata = 32'h0BAD_F00D;
        cyc();
        memAck = 1'b0;
        #1;
        check("nto_lv", 32'(loadValid), 32'd1);
        check("nto_data", loadData, 32'h0BAD_F00D);
        check("nto_busError", 32'(busError), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the 32-bit ALU.
- Consumes the ALU result as an effective byte address, plus the register store operand and the size/sign controls from the control unit.
- Runs one byte, halfword or word transaction on a req/ack data-memory bus and stalls the core until the transaction completes.
- Returns aligned, sign- or zero-extended load data for writeback.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles memReq may stay high without memAck (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- reqValid  input  1  access request this cycle.
- reqWrite  input  1  1 = store, 0 = load.
- reqSize  input  2  00 byte, 01 half, 10 word; 11 is illegal and is treated as misaligned.
- reqUnsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- aluResult  input  32  effective byte address.
- storeData  input  32  store operand, right-justified.
- stall  output  1  hold the core pipeline.
- loadData  output  32  extended load result.
- loadValid  output  1  one-cycle pulse, loadData valid.
- misaligned  output  1  one-cycle pulse, request rejected.
- busError  output  1  one-cycle timeout pulse.
- memReq  output  1  bus request.
- memWe  output  1  bus write enable.
- memAddr  output  32  word address, with bits [1:0] = 00.
- memBe  output  4  byte enables.
- memWdata  output  32  lane-replicated store data.
- memRdata  input  32  read data, valid with memAck.
- memAck  input  1  transaction-complete strobe.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high.
  - On reset: state IDLE; stall, loadValid, misaligned, busError, memReq and memWe are 0; loadData, memAddr, memBe and memWdata are 0.
- States:
  - IDLE: no transaction in progress.
  - BUSY: memReq is high, waiting for memAck.
  - RESP: load result is presented.
- Alignment:
  - Byte: always legal.
  - Half: requires aluResult[0] = 0.
  - Word: requires aluResult[1:0] = 00.
  - Size 11: always illegal.
- IDLE with reqValid and an illegal access:
  - misaligned pulses on the next cycle.
  - No bus activity, stall stays 0, state stays IDLE.
- IDLE with reqValid and a legal access:
  - stall is asserted combinationally in the same cycle.
  - On the next edge, register memAddr = {aluResult[31:2], 00}, memWe = reqWrite, memBe and memWdata; set memReq = 1 and move to BUSY.
- Byte enables:
  - Byte: memBe = 0001 shifted left by aluResult[1:0].
  - Half: memBe = 0011 if aluResult[1] = 0, else 1100.
  - Word: memBe = 1111.
- Store data replication: byte data is copied into all 4 lanes, halfword data into both halves, word data is passed unchanged.
- BUSY:
  - stall = 1; memReq and all bus outputs are held stable until memAck.
  - On memAck with a store: memReq drops and state returns to IDLE on the same edge; stall is low the following cycle.
  - On memAck with a load: capture the lane selected by the saved offset from memRdata, extend it to 32 bits, and move to RESP.
- RESP: loadValid = 1 and stall = 0 for exactly one cycle, then IDLE. loadData holds its value until the next load completes.
- Minimum latency:
  - Store: 2 cycles of stall.
  - Load: 2 cycles of stall, with loadValid on the third cycle.
- Boundary conditions:
  - memAck while in IDLE or RESP is ignored.
  - reqValid while in BUSY or RESP is ignored; the core is stalled or advancing, so it does not happen in valid use.
  - rst while in BUSY aborts the transaction: memReq = 0 on the next edge, and no loadValid or busError is raised.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Enabled:
  - A counter clears when BUSY is entered and increments every BUSY cycle without memAck.
  - When the count reaches TIMEOUT_CYCLES: drop memReq, pulse busError for one cycle, give no loadValid, and return to IDLE.
  - If memAck arrives on the terminal cycle, it wins.
- Disabled: BUSY waits indefinitely and busError is tied to 0.

Decomposition:
- Shared header alongside the existing opcode enum holds:
  - size encodings LSU_SIZE_BYTE, LSU_SIZE_HALF, LSU_SIZE_WORD;
  - state encodings LSU_IDLE, LSU_BUSY, LSU_RESP.
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension (inputs: word, offset, size, unsigned).

Test Plan:
- Word load: addr 0x0000_0010, memAck after 3 cycles with rdata 0xDEAD_BEEF -> memAddr 0x10, memBe 1111, stall high 4 cycles, loadValid with loadData 0xDEAD_BEEF.
- Byte loads: addr 0x13, rdata 0x80FF_0000, signed -> memBe 1000, loadData 0xFFFF_FF80; the same access unsigned -> 0x0000_0080.
- Half store: addr 0x22, storeData 0x1234_ABCD, immediate ack -> memWe 1, memBe 1100, memWdata 0xABCD_ABCD, stall 2 cycles, no loadValid.
- Misaligned word: addr 0x0000_0006 -> misaligned pulse, memReq never asserted, stall 0.
- Reset mid-BUSY: rst asserted 2 cycles into a load -> memReq 0 after the edge, no loadValid; the next request completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, memAck never asserted -> busError pulse after 4 BUSY cycles, memReq drops, state returns to IDLE.
